// File: rtl/apb_master_arbiter.sv
// Two-requester APB arbiter: round-robin grant of one shared APB completer port.
// Optional access-phase watchdog is compiled in with `define APB_ARB_TIMEOUT_EN.
module apb_master_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   // requester side
   input  logic [1:0]              S_PSEL,
   input  logic [1:0]              S_PENABLE,
   input  logic [1:0]              S_PWRITE,
   input  logic [2*ADDR_WIDTH-1:0] S_PADDR,
   input  logic [2*DATA_WIDTH-1:0] S_PWDATA,
   output logic [2*DATA_WIDTH-1:0] S_PRDATA,
   output logic [1:0]              S_PREADY,
   output logic [1:0]              S_PSLVERR,
   // completer side
   output logic                    M_PSEL,
   output logic                    M_PENABLE,
   output logic                    M_PWRITE,
   output logic [ADDR_WIDTH-1:0]   M_PADDR,
   output logic [DATA_WIDTH-1:0]   M_PWDATA,
   input  logic [DATA_WIDTH-1:0]   M_PRDATA,
   input  logic                    M_PREADY,
   input  logic                    M_PSLVERR
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t                  state;
   state_t                  state_nxt;

   // grant doubles as the last-grant pointer: it always names the requester
   // that won most recently, which is also the one being served.
   logic                    grant;
   logic                    arb_win;
   logic                    start_xfer;
   logic                    access_timeout;

   logic                    cap_write;
   logic [ADDR_WIDTH-1:0]   cap_addr;
   logic [DATA_WIDTH-1:0]   cap_wdata;
   logic [DATA_WIDTH-1:0]   cap_rdata;
   logic                    cap_slverr;

   // Requester enables are accepted on the port but do not sequence anything.
   logic                    unused_penable;
   assign unused_penable = ^S_PENABLE;

   assign start_xfer = (state == ST_IDLE) && (|S_PSEL);

   always_comb begin
      case (S_PSEL)
         2'b01:   arb_win = 1'b0;
         2'b10:   arb_win = 1'b1;
         2'b11:   arb_win = ~grant;
         default: arb_win = 1'b0;
      endcase
   end

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   logic [CNT_W-1:0] tmo_cnt;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         tmo_cnt <= '0;
      end else if (state == ST_SETUP) begin
         tmo_cnt <= '0;
      end else if ((state == ST_ACCESS) && !M_PREADY) begin
         tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
   end

   // Fires on the last permitted access cycle that still has no M_PREADY.
   assign access_timeout = (state == ST_ACCESS) && !M_PREADY &&
                           (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

   assign access_timeout = 1'b0;
`endif

   // NOTE: state and every captured register use non-blocking assignments so
   // all flops update together on the edge, independent of block ordering.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         grant      <= 1'b1;
         cap_write  <= 1'b0;
         cap_addr   <= '0;
         cap_wdata  <= '0;
         cap_rdata  <= '0;
         cap_slverr <= 1'b0;
      end else begin
         if (start_xfer) begin
            grant     <= arb_win;
            cap_write <= S_PWRITE[arb_win];
            cap_addr  <= arb_win ? S_PADDR[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                 : S_PADDR[ADDR_WIDTH-1:0];
            cap_wdata <= arb_win ? S_PWDATA[2*DATA_WIDTH-1:DATA_WIDTH]
                                 : S_PWDATA[DATA_WIDTH-1:0];
         end
         if ((state == ST_ACCESS) && M_PREADY) begin
            cap_rdata  <= cap_write ? '0 : M_PRDATA;
            cap_slverr <= M_PSLVERR;
         end else if (access_timeout) begin
            cap_rdata  <= '0;
            cap_slverr <= 1'b1;
         end
      end
   end

   // NOTE: every output and next-state value gets a default before the case,
   // so no path through this block can infer a latch.
   always_comb begin
      state_nxt = state;
      M_PSEL    = 1'b0;
      M_PENABLE = 1'b0;
      M_PWRITE  = 1'b0;
      M_PADDR   = '0;
      M_PWDATA  = '0;
      S_PREADY  = '0;
      S_PSLVERR = '0;
      S_PRDATA  = '0;

      case (state)
         ST_IDLE: begin
            if (|S_PSEL) begin
               state_nxt = ST_SETUP;
            end
         end

         ST_SETUP: begin
            M_PSEL    = 1'b1;
            M_PWRITE  = cap_write;
            M_PADDR   = cap_addr;
            M_PWDATA  = cap_wdata;
            state_nxt = ST_ACCESS;
         end

         ST_ACCESS: begin
            M_PSEL    = 1'b1;
            M_PENABLE = 1'b1;
            M_PWRITE  = cap_write;
            M_PADDR   = cap_addr;
            M_PWDATA  = cap_wdata;
            if (M_PREADY || access_timeout) begin
               state_nxt = ST_RESP;
            end
         end

         ST_RESP: begin
            S_PREADY[grant]  = 1'b1;
            S_PSLVERR[grant] = cap_slverr;
            if (grant) begin
               S_PRDATA[2*DATA_WIDTH-1:DATA_WIDTH] = cap_rdata;
            end else begin
               S_PRDATA[DATA_WIDTH-1:0] = cap_rdata;
            end
            state_nxt = ST_IDLE;
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: APB address width.
REQ-002 Parameter DATA_WIDTH, default 32: APB data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: access-phase cycle limit; used only under APB_ARB_TIMEOUT_EN.
REQ-004 ACLK  input  1  single clock; all logic on rising edge.
REQ-005 ARESETn  input  1  asynchronous, active-low reset.
REQ-006 S_PSEL  input  2  per-requester select; bit i belongs to requester i.
REQ-007 S_PENABLE  input  2  per-requester enable; accepted but not used to sequence.
REQ-008 S_PWRITE  input  2  per-requester direction (1 = write).
REQ-009 S_PADDR  input  2*ADDR_WIDTH  requester i address in slice i.
REQ-010 S_PWDATA  input  2*DATA_WIDTH  requester i write data in slice i.
REQ-011 S_PRDATA  output  2*DATA_WIDTH  read data returned to requester i in slice i.
REQ-012 S_PREADY  output  2  completion to requester i.
REQ-013 S_PSLVERR  output  2  error to requester i.
REQ-014 M_PSEL, M_PENABLE, M_PWRITE  output  1 each  shared APB completer controls.
REQ-015 M_PADDR  output  ADDR_WIDTH, M_PWDATA  output  DATA_WIDTH  shared completer address and write data.
REQ-016 M_PRDATA  input  DATA_WIDTH, M_PREADY  input  1, M_PSLVERR  input  1  completer response.

Function
REQ-017 States are IDLE, SETUP, ACCESS and RESP.
REQ-018 IDLE: if any S_PSEL bit is set, select grant g, capture S_PWRITE[g], S_PADDR slice g and S_PWDATA slice g, and go to SETUP; otherwise stay in IDLE.
REQ-019 Arbitration is round-robin: a sole requester wins; on a tie, the requester not granted last wins; the last-grant pointer updates on every grant.
REQ-020 SETUP (one cycle): M_PSEL=1 and M_PENABLE=0, with captured address, data and direction on the M_ outputs; then go to ACCESS.
REQ-021 ACCESS: M_PSEL=1 and M_PENABLE=1, held until M_PREADY=1. On that edge, capture M_PRDATA (reads only, else 0) and M_PSLVERR, then go to RESP.
REQ-022 RESP (one cycle): S_PREADY[g]=1 and S_PSLVERR[g]=captured value; S_PRDATA slice g = captured data; M_PSEL=0 and M_PENABLE=0; then go to IDLE.
REQ-023 Outside RESP, all S_PREADY, S_PSLVERR and S_PRDATA bits are 0; a non-granted requester is stalled via S_PREADY=0.
REQ-024 Latency: request sampled in IDLE at edge N; SETUP at N+1; first ACCESS at N+2; S_PREADY at the cycle after the M_PREADY edge. Minimum is 4 cycles per transfer.
REQ-025 M_PADDR, M_PWDATA and M_PWRITE are held stable from SETUP through ACCESS and are 0 in IDLE.
REQ-026 A request withdrawn before IDLE samples it is ignored; a request withdrawn after grant still completes on the M_ side and its response is still issued.
REQ-027 A requester re-asserting S_PSEL in the IDLE cycle after its RESP is a new transfer and is arbitrated normally.

Reset
REQ-028 While ARESETn=0: state=IDLE; all outputs 0; captured registers 0; last-grant pointer = 1, so requester 0 wins the first tie.
REQ-029 Reset asserted mid-transfer aborts it immediately; no S_PREADY is issued for the aborted transfer.

Configuration
REQ-030 Macro APB_ARB_TIMEOUT_EN defined: a counter clears on entry to ACCESS; if M_PREADY is not seen within TIMEOUT_CYCLES access cycles, the arbiter goes to RESP with S_PSLVERR[g]=1 and S_PRDATA slice g = 0.
REQ-031 Macro APB_ARB_TIMEOUT_EN undefined: no counter exists, and ACCESS waits indefinitely for M_PREADY.

Verification
REQ-032 Requester 0 writes 0xA5A5A5A5 to 0x1000_0000, completer ready in first access cycle -> M_ side SETUP then ACCESS with those values; S_PREADY[0] pulses 1 cycle later; S_PSLVERR[0]=0.
REQ-033 Requester 1 reads 0x1000_0004, completer returns 0xDEADBEEF after 2 wait states -> S_PRDATA slice 1 = 0xDEADBEEF during S_PREADY[1]; slice 0 stays 0.
REQ-034 Both requesters select in the same cycle right after reset -> requester 0 served first, requester 1 next; repeated simultaneous requests alternate 0,1,0,1.
REQ-035 Completer returns M_PSLVERR=1 on a write -> S_PSLVERR[g]=1 for exactly the RESP cycle.
REQ-036 ARESETn driven low during ACCESS -> all M_ and S_ outputs 0 immediately; the next request after reset is handled normally.
REQ-037 With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, M_PREADY held 0 -> RESP after 4 access cycles with S_PSLVERR[g]=1 and data 0.
